// File: rtl/mac_pkg.sv
// Shared definitions for the 4-bit signed MAC stage and its result buffer.
package mac_pkg;

  localparam int MAC_IN_W    = 4;
  localparam int MAC_OUT_W   = 11;
  localparam int MAC_VEC_LEN = 8;

  // Default number of entries in the MAC result FIFO.
  localparam int RES_DEPTH   = 4;

  typedef logic signed [MAC_OUT_W-1:0] mac_result_t;

endpackage

// File: rtl/mac_result_buffer.sv
// mac_result_buffer: show-ahead FIFO that captures MAC results on the
// single-cycle out_valid pulse and presents them over valid/ready.
// Optional build macro MAC_RESULT_RELU_EN: negative results are stored as 0.
//
// Handshake: the consumer takes res_data when res_valid && res_ready are both
// high at a rising clock edge. res_valid is high whenever the FIFO is non-empty
// and does not depend on res_ready. The producer side has no back-pressure: a
// result arriving while the FIFO is full and not being popped is dropped and
// recorded in the sticky overflow flag.
module mac_result_buffer
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_OUT_W,
  parameter int DEPTH  = RES_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] mac_out,
  input  logic                     out_valid,
  output logic signed [DATA_W-1:0] res_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] wr_data;

  // Status flags come straight from the registered occupancy count.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign res_valid = !empty;
  assign count     = count_q;
  assign overflow  = ovf_q;

  // Show-ahead head; forced to zero while empty so reset clears it at once.
  assign res_data  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop  = res_valid && res_ready;
  assign push = out_valid && (!full || pop);
  assign drop = out_valid && full && !pop;

  // Value written on push, optionally clamped at zero.
  always_comb begin
`ifdef MAC_RESULT_RELU_EN
    wr_data = mac_out[DATA_W-1] ? '0 : mac_out;
`else
    wr_data = mac_out;
`endif
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A fresh drop outranks a clear requested in the same cycle.
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_mac_result_buffer.sv
// Testbench for mac_result_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_mac_result_buffer;

  localparam int DATA_W = 11;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] mac_out;
  logic              out_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              clear_ovf;

  mac_result_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .mac_out   (mac_out),
    .out_valid (out_valid),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ovf;
  int                n_checks;
  int                n_fail;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Value the buffer is expected to hold for a given MAC result.
  function automatic logic [DATA_W-1:0] stored(input logic [DATA_W-1:0] v);
`ifdef MAC_RESULT_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    logic [DATA_W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check_eq({tag, "_valid"}, 32'(res_valid), 32'(exp_q.size() > 0));
    check_eq({tag, "_data"},  32'(res_data),  32'(head));
    check_eq({tag, "_count"}, 32'(count),     32'(exp_q.size()));
    check_eq({tag, "_full"},  32'(full),      32'(exp_q.size() == DEPTH));
    check_eq({tag, "_empty"}, 32'(empty),     32'(exp_q.size() == 0));
    check_eq({tag, "_ovf"},   32'(overflow),  32'(exp_ovf));
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs, advances the model by the FIFO rules and
  // checks every output shortly after the edge.
  task automatic step(input string tag, input logic ov, input logic [DATA_W-1:0] d,
                      input logic rr, input logic co);
    logic m_pop, m_push, m_drop;
    out_valid = ov;
    mac_out   = d;
    res_ready = rr;
    clear_ovf = co;
    m_pop  = (exp_q.size() > 0) && rr;
    m_push = ov && ((exp_q.size() < DEPTH) || m_pop);
    m_drop = ov && (exp_q.size() == DEPTH) && !m_pop;
    @(posedge clk);
    #1;
    if (m_pop)  void'(exp_q.pop_front());
    if (m_push) exp_q.push_back(stored(d));
    if (m_drop)  exp_ovf = 1'b1;
    else if (co) exp_ovf = 1'b0;
    out_valid = 1'b0;
    res_ready = 1'b0;
    clear_ovf = 1'b0;
    check_outputs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] neg37;
    n_checks  = 0;
    n_fail    = 0;
    exp_ovf   = 1'b0;
    reset     = 1'b1;
    mac_out   = '0;
    out_valid = 1'b0;
    res_ready = 1'b0;
    clear_ovf = 1'b0;

    // Reset state
    #12;
    check_outputs("rst");
    reset = 1'b0;

    // Single result then consume it
    step("t1_push", 1'b1, 11'd100, 1'b0, 1'b0);
    check_eq("t1_head100", 32'(res_data), 32'd100);
    step("t1_pop", 1'b0, '0, 1'b1, 1'b0);
    check_eq("t1_empty", 32'(empty), 32'd1);

    // Fill with signed extremes, then drain in order
    step("t2_a", 1'b1, 11'(-5),    1'b0, 1'b0);
    step("t2_b", 1'b1, 11'(7),     1'b0, 1'b0);
    step("t2_c", 1'b1, 11'(-1024), 1'b0, 1'b0);
    step("t2_d", 1'b1, 11'(1023),  1'b0, 1'b0);
    check_eq("t2_full", 32'(full), 32'd1);
    check_eq("t2_head", 32'(res_data), 32'(11'h7FB));
    for (int i = 0; i < 4; i++) step("t2_drain", 1'b0, '0, 1'b1, 1'b0);

    // Drop on a full FIFO sets overflow; clear_ovf clears it
    for (int i = 0; i < 4; i++) step("t3_fill", 1'b1, 11'($urandom_range(0, 2047)), 1'b0, 1'b0);
    step("t3_drop", 1'b1, 11'd42, 1'b0, 1'b0);
    check_eq("t3_ovf_set", 32'(overflow), 32'd1);
    step("t3_clear", 1'b0, '0, 1'b0, 1'b1);

    // Full with simultaneous push and pop: no drop
    step("t4_both", 1'b1, 11'd9, 1'b1, 1'b0);
    check_eq("t4_cnt4", 32'(count), 32'd4);

    // Drop and clear in the same cycle: drop wins
    step("t4_setwins", 1'b1, 11'd5, 1'b0, 1'b1);
    check_eq("t4_ovf_hold", 32'(overflow), 32'd1);

    // Asynchronous reset mid-drain with three entries queued
    step("t5_pop", 1'b0, '0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_outputs("t5_async");
    #1;
    reset = 1'b0;

    // count==1 with push and pop: the pushed value becomes the head
    step("t6_one", 1'b1, 11'd300, 1'b0, 1'b0);
    step("t6_swap", 1'b1, 11'd301, 1'b1, 1'b0);
    check_eq("t6_head", 32'(res_data), 32'd301);
    step("t6_pop", 1'b0, '0, 1'b1, 1'b0);

    // res_ready while empty does nothing
    step("t7_empty_rdy", 1'b0, '0, 1'b1, 1'b0);

    // Negative and positive result: clamped only when RELU is built in
    neg37 = 11'(-37);
    step("t8_neg", 1'b1, neg37, 1'b0, 1'b0);
    step("t8_pos", 1'b1, 11'd37, 1'b0, 1'b0);
`ifdef MAC_RESULT_RELU_EN
    check_eq("t8_relu_head", 32'(res_data), 32'd0);
`else
    check_eq("t8_raw_head", 32'(res_data), 32'(neg37));
`endif
    step("t8_pop", 1'b0, '0, 1'b1, 1'b0);
    check_eq("t8_second", 32'(res_data), 32'd37);
    step("t8_pop2", 1'b0, '0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      v = 11'($urandom_range(0, 2047));
      step("rnd",
           1'($urandom_range(0, 99) < 60),
           v,
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 10));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_result_buffer.md
Name: mac_result_buffer

Overview:
- Sits directly downstream of the 4-bit signed MAC stage.
- Captures each 11-bit signed dot-product result on the MAC's single-cycle out_valid pulse and holds it in a small show-ahead FIFO.
- Presents results to the consumer over a valid/ready handshake.
- Flags results lost to overflow with a sticky bit.

Parameters:
- DATA_W, 11, result width; matches the MAC result width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 3, occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mac_out  input  DATA_W  signed result from the MAC stage.
- out_valid  input  1  single-cycle pulse; mac_out is valid in that cycle.
- res_data  output  DATA_W  signed head-of-FIFO result.
- res_valid  output  1  high when FIFO is non-empty.
- res_ready  input  1  consumer accepts res_data when res_valid && res_ready at posedge.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a result was dropped.
- clear_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Clock and reset:
  - Single clock domain, posedge only.
  - reset is asynchronous and active-high.
  - On reset: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, res_valid=0, res_data=0, overflow=0.
  - Storage array contents are not reset.
- Push:
  - push = out_valid && (!full || pop).
  - On push, mac_out is written at wr_ptr; wr_ptr increments mod DEPTH.
- Pop:
  - pop = res_valid && res_ready.
  - On pop, rd_ptr increments mod DEPTH.
- Show-ahead output: res_data = mem[rd_ptr] when !empty, else 0; res_valid = !empty.
- Latency: a result pushed at edge N is visible on res_data/res_valid after edge N. No same-cycle bypass from mac_out to res_data.
- Occupancy:
  - count +1 on push only.
  - count -1 on pop only.
  - count unchanged when both or neither occur.
  - full and empty are derived from count.
- Simultaneous push and pop:
  - When full, both proceed and count stays DEPTH; no overflow.
  - When count==1, both proceed; the new head is the pushed value and count stays 1.
- Overflow:
  - out_valid && full && !pop drops the result and sets overflow the same edge.
  - overflow holds until clear_ovf=1 at a posedge.
  - If clear_ovf and a new drop occur in the same cycle, the set wins (overflow stays 1).
- Empty: res_ready while empty has no effect; pointers and count are unchanged.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset mid-operation: all queued results are discarded and the outputs return to reset values asynchronously.
- Arithmetic: data stored unmodified (two's complement, DATA_W bits), except as stated under Optional Feature.
- No state machine beyond the pointer/count control; all outputs are registered or derived from registered state.

Optional Feature:
- Macro: MAC_RESULT_RELU_EN.
- Defined: on push, a negative mac_out (MSB=1) is stored as 0; non-negative values are stored unchanged. The overflow drop decision is unaffected.
- Undefined: values are stored unmodified.

Decomposition:
- Shared package mac_pkg:
  - MAC_IN_W=4, MAC_OUT_W=11, MAC_VEC_LEN=8.
  - Default RES_DEPTH=4.
  - Typedef mac_result_t, signed [MAC_OUT_W-1:0].
- DATA_W defaults from MAC_OUT_W.
- No sub-module: storage, pointers and count live in one module of about 150 lines.

Test Plan:
- Reset, then one out_valid with mac_out=11'sd100 -> res_valid=1, res_data=100, count=1 one edge later; res_ready pulse -> empty=1, count=0.
- Push -5, 7, -1024, 1023 with res_ready=0 -> full=1, count=4; drain -> results in that order, signed values intact.
- Full FIFO and out_valid with mac_out=42, res_ready=0 -> 42 dropped, overflow=1, count=4; clear_ovf -> overflow=0.
- Full FIFO with out_valid=1 (mac_out=9) and res_ready=1 in the same cycle -> head popped, 9 enqueued, count=4, overflow=0.
- Assert reset asynchronously mid-drain with count=3 -> res_valid, count, res_data, overflow go to 0 immediately, without a clock edge.
- With MAC_RESULT_RELU_EN defined, push -37 then 37 -> res_data reads 0 then 37; with it undefined -> -37 then 37.
